// File: rtl/wavegen_pkg.sv
// Shared types and helpers for the waveform generator DAC path:
// transmitter FSM states and the MCP4922-style command frame layout.
package wavegen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_CS_GAP,
    ST_LDAC
  } dac_state_e;

  localparam int FRAME_AB_POS   = 15;
  localparam int FRAME_BUF_POS  = 14;
  localparam int FRAME_GA_POS   = 13;
  localparam int FRAME_SHDN_POS = 12;

  function automatic logic [15:0] build_dac_frame(
    input logic        ch,
    input logic        buf_bit,
    input logic        ga_n,
    input logic        shdn_n,
    input logic [11:0] word
  );
    logic [15:0] frame;
    frame                 = '0;
    frame[11:0]           = word;
    frame[FRAME_AB_POS]   = ch;
    frame[FRAME_BUF_POS]  = buf_bit;
    frame[FRAME_GA_POS]   = ga_n;
    frame[FRAME_SHDN_POS] = shdn_n;
    return frame;
  endfunction

endpackage

// File: rtl/spi_shift16.sv
// 16-bit SPI mode-0 shifter: MSB first, MOSI changes only at SCK falling
// edges, each half-period lasting CLK_DIV clk cycles.
module spi_shift16 #(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [15:0] frame_i,
  input  logic        start_i,
  output logic        sck_o,
  output logic        mosi_o,
  output logic        done_o
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic        active_q, active_d;
  logic        sck_q, sck_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;
  logic        divEnd;

  assign divEnd = (div_q == DIV_LAST);
  // Asserted during the final cycle of bit 15's high half, so the owner can
  // leave its shift state on the same edge that drops SCK.
  assign done_o = active_q && sck_q && divEnd && (bit_q == 4'd15);
  assign sck_o  = sck_q;
  assign mosi_o = shreg_q[15];

  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    if (load_i) begin
      shreg_d = frame_i;
    end
    if (start_i) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
    end else if (active_q) begin
      if (divEnd) begin
        div_d = '0;
        sck_d = ~sck_q;
        if (sck_q) begin
          shreg_d = {shreg_q[14:0], 1'b0};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            active_d = 1'b0;
          end
        end
      end else begin
        div_d = div_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Dual-channel DAC SPI transmitter: per sample strobe sends frame A, then
// frame B, then pulses LDAC so both DAC outputs update together.
module dac_spi_tx
  import wavegen_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 5,
  parameter int unsigned CS_SETUP_CYC = 2,
  parameter int unsigned CS_GAP_CYC   = 4,
  parameter int unsigned LDAC_CYC     = 4,
  parameter logic        BUF_BIT      = 1'b0,
  parameter logic        GA_N_BIT     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_sampling,
  input  logic        enableA,
  input  logic        enableB,
  input  logic [11:0] dacA_word,
  input  logic [11:0] dacB_word,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP_CYC - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_GAP_CYC - 1);
  localparam logic [15:0] LDAC_LAST  = 16'(LDAC_CYC - 1);

  dac_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        frameB_q, frameB_d;
  logic [11:0] wordB_q, wordB_d;
  logic        enB_q, enB_d;
  logic        overrun_q, overrun_d;
  logic        csN_q, csN_d;
  logic        ldacN_q, ldacN_d;
  logic        busy_q, busy_d;
  logic        frameDone_q, frameDone_d;
  logic        shLoad, shStart, shDone;
  logic [15:0] shFrame;

  spi_shift16 #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (shLoad),
    .frame_i (shFrame),
    .start_i (shStart),
    .sck_o   (spi_sck),
    .mosi_o  (spi_mosi),
    .done_o  (shDone)
  );

  // Frame A goes straight into the shift register at the strobe; only the
  // channel-B word and enable need shadowing until the gap ends.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frameB_d  = frameB_q;
    wordB_d   = wordB_q;
    enB_d     = enB_q;
    overrun_d = overrun_q;
    shLoad    = 1'b0;
    shStart   = 1'b0;
    shFrame   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (clk_sampling) begin
          wordB_d  = dacB_word;
          enB_d    = enableB;
          shFrame  = build_dac_frame(1'b0, BUF_BIT, GA_N_BIT, enableA, dacA_word);
          shLoad   = 1'b1;
          frameB_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          shStart = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SHIFT: begin
        if (shDone) begin
          cnt_d   = '0;
          state_d = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = frameB_q ? ST_LDAC : ST_CS_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_CS_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d    = '0;
          shFrame  = build_dac_frame(1'b1, BUF_BIT, GA_N_BIT, enB_q, wordB_q);
          shLoad   = 1'b1;
          frameB_d = 1'b1;
          state_d  = ST_CS_SETUP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_LDAC: begin
        if (cnt_q == LDAC_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clk_sampling && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // Pin levels are decoded from the next state so they register in step
  // with the state they belong to.
  always_comb begin
    csN_d       = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) ||
                    (state_d == ST_CS_HOLD));
    ldacN_d     = (state_d != ST_LDAC);
    busy_d      = (state_d != ST_IDLE);
    frameDone_d = (state_q == ST_LDAC) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frameB_q    <= 1'b0;
      wordB_q     <= '0;
      enB_q       <= 1'b0;
      overrun_q   <= 1'b0;
      csN_q       <= 1'b1;
      ldacN_q     <= 1'b1;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frameB_q    <= frameB_d;
      wordB_q     <= wordB_d;
      enB_q       <= enB_d;
      overrun_q   <= overrun_d;
      csN_q       <= csN_d;
      ldacN_q     <= ldacN_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign spi_cs_n   = csN_q;
  assign dac_ldac_n = ldacN_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;
  assign overrun    = overrun_q;

endmodule
